// File: rtl/sprite_blitter.sv
// sprite_blitter: integer-scaled, animated sprite layer for the VGA pixel path, output registered 2 cycles after the pixel.
// Build option SPRITE_FLIP_EN: when defined flip_x mirrors the sprite horizontally, otherwise flip_x is ignored.
//
// Animation state | meaning
// tick_q          | vs falling edges seen while showing the current frame, 0..FRAME_PERIOD-1
// frame_q         | animation frame selecting the ROM base address, 0..FRAMES-1
// vs_q            | vs sampled last cycle, reference for falling-edge detection
module sprite_blitter #(
    parameter int SPR_W        = 16,
    parameter int SPR_H        = 16,
    parameter int SCALE_SH     = 2,
    parameter int FRAMES       = 4,
    parameter int FRAME_PERIOD = 8,
    parameter int IDX_W        = 2,
    parameter int ADDR_W       = $clog2(FRAMES*SPR_W*SPR_H)
) (
    input  logic              vga_clk,
    input  logic              reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              vs,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              sprite_en,
    input  logic              anim_en,
    input  logic              flip_x,
    input  logic [3:0]        bg_red,
    input  logic [3:0]        bg_green,
    input  logic [3:0]        bg_blue,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [IDX_W-1:0]  pal_index,
    input  logic [3:0]        pal_red,
    input  logic [3:0]        pal_green,
    input  logic [3:0]        pal_blue,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              hit
);

    localparam int FRAME_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TICK_W   = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
    localparam int FRAME_SZ = SPR_W * SPR_H;
`ifdef SPRITE_FLIP_EN
    localparam logic FLIP_EN = 1'b1;
`else
    localparam logic FLIP_EN = 1'b0;
`endif

    logic [10:0] dx;
    logic [10:0] dy;
    logic [9:0]  lx_raw;
    logic [9:0]  lx;
    logic [9:0]  ly;
    logic        in_box;

    logic [TICK_W-1:0]  tick_q;
    logic [TICK_W-1:0]  tick_d;
    logic [FRAME_W-1:0] frame_q;
    logic [FRAME_W-1:0] frame_d;
    logic               vs_q;
    logic               vs_fall;

    logic        in_box_q;
    logic        blank_q;
    logic [11:0] bg_q;
    logic [11:0] pix_d;
    logic        hit_d;

    // Bit 10 of the 11-bit difference is the sign: left of / above the sprite is outside the box.
    assign dx     = {1'b0, DrawX} - {1'b0, pos_x};
    assign dy     = {1'b0, DrawY} - {1'b0, pos_y};
    assign lx_raw = dx[9:0] >> SCALE_SH;
    assign ly     = dy[9:0] >> SCALE_SH;
    assign in_box = sprite_en & ~dx[10] & ~dy[10]
                  & (lx_raw < 10'(SPR_W)) & (ly < 10'(SPR_H));
    assign lx     = (FLIP_EN & flip_x) ? (10'(SPR_W - 1) - lx_raw) : lx_raw;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            tick_q  <= '0;
            frame_q <= '0;
            vs_q    <= 1'b1;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
            vs_q    <= vs;
        end
    end

    always_comb begin
        vs_fall = vs_q & ~vs;
        tick_d  = tick_q;
        frame_d = frame_q;
        if (vs_fall && anim_en) begin
            if (tick_q == TICK_W'(FRAME_PERIOD - 1)) begin
                tick_d  = '0;
                frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + FRAME_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end
    end

    always_comb begin
        rom_address = '0;
        if (in_box)
            rom_address = ADDR_W'(32'(frame_q) * 32'(FRAME_SZ) + 32'(ly) * 32'(SPR_W) + 32'(lx));
    end

    // Delay the per-pixel qualifiers by the ROM's one-cycle read latency.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            in_box_q <= 1'b0;
            blank_q  <= 1'b0;
            bg_q     <= '0;
        end else begin
            in_box_q <= in_box;
            blank_q  <= blank;
            bg_q     <= {bg_red, bg_green, bg_blue};
        end
    end

    assign pal_index = rom_q;

    always_comb begin
        pix_d = 12'h000;
        hit_d = 1'b0;
        if (!blank_q) begin
            pix_d = 12'h000;
            hit_d = 1'b0;
        end else if (in_box_q && (rom_q != '0)) begin
            pix_d = {pal_red, pal_green, pal_blue};
            hit_d = 1'b1;
        end else begin
            pix_d = bg_q;
            hit_d = 1'b0;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
            hit   <= 1'b0;
        end else begin
            {red, green, blue} <= pix_d;
            hit                <= hit_d;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table vectors, hand sequences and random pixels against a behavioural model of sprite_blitter.
// Expectations for flip_x follow SPRITE_FLIP_EN as seen by this bench.
module tb_sprite_blitter;

    localparam int SPR_W        = 16;
    localparam int SPR_H        = 16;
    localparam int SCALE_SH     = 2;
    localparam int FRAMES       = 4;
    localparam int FRAME_PERIOD = 8;
    localparam int IDX_W        = 2;
    localparam int ADDR_W       = 10;
    localparam int SCALE        = 1 << SCALE_SH;
`ifdef SPRITE_FLIP_EN
    localparam bit FLIP_ON = 1'b1;
`else
    localparam bit FLIP_ON = 1'b0;
`endif

    logic              vga_clk = 1'b0;
    logic              reset = 1'b1;
    logic [9:0]        DrawX = '0;
    logic [9:0]        DrawY = '0;
    logic [9:0]        pos_x = '0;
    logic [9:0]        pos_y = '0;
    logic              blank = 1'b0;
    logic              vs = 1'b1;
    logic              sprite_en = 1'b0;
    logic              anim_en = 1'b0;
    logic              flip_x = 1'b0;
    logic [3:0]        bg_red = '0;
    logic [3:0]        bg_green = '0;
    logic [3:0]        bg_blue = '0;
    logic [ADDR_W-1:0] rom_address;
    logic [IDX_W-1:0]  rom_q;
    logic [IDX_W-1:0]  pal_index;
    logic [3:0]        pal_red;
    logic [3:0]        pal_green;
    logic [3:0]        pal_blue;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              hit;

    logic [IDX_W-1:0]  rom_mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad = 0;
    int m_tick = 0;
    int m_frame = 0;
    bit m_vs_prev = 1'b1;
    logic [12:0] expq [$];

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] px;
        logic [9:0] py;
        logic       en;
        logic       flip;
        int         exp_addr;
    } vec_t;
    vec_t tab [12];

    sprite_blitter dut (
        .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .vs(vs), .pos_x(pos_x), .pos_y(pos_y),
        .sprite_en(sprite_en), .anim_en(anim_en), .flip_x(flip_x),
        .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
        .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
        .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .red(red), .green(green), .blue(blue), .hit(hit)
    );

    always #5 vga_clk = ~vga_clk;

    always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

    function automatic logic [11:0] pal_of(input logic [IDX_W-1:0] idx);
        case (idx)
            2'd1:    return 12'h123;
            2'd2:    return 12'hF81;
            2'd3:    return 12'h7AE;
            default: return 12'h000;
        endcase
    endfunction

    always_comb {pal_red, pal_green, pal_blue} = pal_of(pal_index);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_pixel(output int addr, output bit inb);
        int dx, dy, lx, ly;
        dx  = int'(DrawX) - int'(pos_x);
        dy  = int'(DrawY) - int'(pos_y);
        inb = sprite_en && dx >= 0 && dy >= 0 && (dx / SCALE) < SPR_W && (dy / SCALE) < SPR_H;
        lx  = dx / SCALE;
        ly  = dy / SCALE;
        if (FLIP_ON && flip_x) lx = SPR_W - 1 - lx;
        addr = inb ? (m_frame * SPR_W * SPR_H + ly * SPR_W + lx) : 0;
    endfunction

    task automatic model_reset();
        m_tick = 0;
        m_frame = 0;
        m_vs_prev = 1'b1;
        expq.delete();
        expq.push_back(13'h0);
        expq.push_back(13'h0);
    endtask

    // Called at posedge+1 with this cycle's inputs already driven; returns at the next posedge+1.
    task automatic cycle(input int tab_addr);
        int a;
        bit inb;
        logic [IDX_W-1:0] v;
        logic [12:0] e;
        chk("pal_index", 32'(pal_index), 32'(rom_q));
        if (expq.size() >= 2) begin
            e = expq.pop_front();
            chk("pixel_rgb", 32'({red, green, blue}), 32'(e[11:0]));
            chk("pixel_hit", 32'(hit), 32'(e[12]));
        end
        #1;
        model_pixel(a, inb);
        chk("rom_address", 32'(rom_address), 32'(a));
        if (tab_addr >= 0) chk("table_addr", 32'(rom_address), 32'(tab_addr));
        v = rom_mem[a];
        if (!blank) e = 13'h0;
        else if (inb && v != '0) e = {1'b1, pal_of(v)};
        else e = {1'b0, bg_red, bg_green, bg_blue};
        expq.push_back(e);
        if (m_vs_prev && !vs && anim_en) begin
            m_tick++;
            if (m_tick == FRAME_PERIOD) begin
                m_tick = 0;
                m_frame = (m_frame + 1) % FRAMES;
            end
        end
        m_vs_prev = vs;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic set_px(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        {bg_red, bg_green, bg_blue} = 12'($urandom);
    endtask

    task automatic vs_edges(input int n);
        for (int k = 0; k < n; k++) begin
            vs = 1'b0;
            cycle(-1);
            vs = 1'b1;
            cycle(-1);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = IDX_W'($urandom_range(0, 3));

        tab[0]  = '{10'd104, 10'd58,  10'd100, 10'd50,  1'b1, 1'b0, 33};
        tab[1]  = '{10'd99,  10'd58,  10'd100, 10'd50,  1'b1, 1'b0, 0};
        tab[2]  = '{10'd164, 10'd58,  10'd100, 10'd50,  1'b1, 1'b0, 0};
        tab[3]  = '{10'd163, 10'd113, 10'd100, 10'd50,  1'b1, 1'b0, 255};
        tab[4]  = '{10'd104, 10'd58,  10'd100, 10'd50,  1'b0, 1'b0, 0};
        tab[5]  = '{10'd104, 10'd49,  10'd100, 10'd50,  1'b1, 1'b0, 0};
        tab[6]  = '{10'd104, 10'd114, 10'd100, 10'd50,  1'b1, 1'b0, 0};
        tab[7]  = '{10'd5,   10'd0,   10'd0,   10'd0,   1'b1, 1'b0, 1};
        tab[8]  = '{10'd100, 10'd50,  10'd100, 10'd50,  1'b1, 1'b1, FLIP_ON ? 15 : 0};
        tab[9]  = '{10'd104, 10'd58,  10'd100, 10'd50,  1'b1, 1'b1, FLIP_ON ? 46 : 33};
        tab[10] = '{10'd1010, 10'd1020, 10'd1000, 10'd1000, 1'b1, 1'b0, 82};
        tab[11] = '{10'd5,   10'd10,  10'd900, 10'd0,   1'b1, 1'b0, 0};

        reset = 1'b1;
        repeat (3) @(posedge vga_clk);
        #1;
        chk("reset_rgb", 32'({red, green, blue}), 32'h0);
        chk("reset_hit", 32'(hit), 32'h0);
        reset = 1'b0;
        model_reset();

        // Address and box vectors, frame 0.
        blank = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pos_x = tab[i].px;
            pos_y = tab[i].py;
            sprite_en = tab[i].en;
            flip_x = tab[i].flip;
            set_px(int'(tab[i].x), int'(tab[i].y));
            cycle(tab[i].exp_addr);
        end

        // Transparency, opaque hit and blanking around address 33.
        pos_x = 10'd100; pos_y = 10'd50; sprite_en = 1'b1; flip_x = 1'b0;
        set_px(99, 58);  cycle(0);
        rom_mem[33] = 2'd0;
        set_px(104, 58); cycle(33);
        rom_mem[33] = 2'd2;
        set_px(104, 58); cycle(33);
        set_px(99, 58);  cycle(0);
        blank = 1'b0;
        set_px(104, 58); cycle(33);
        blank = 1'b1;
        set_px(164, 58); cycle(0);
        set_px(164, 58); cycle(0);
        chk("opaque_then_bg_hit", 32'(hit), 32'h0);

        // Animation: probe pixel at the sprite origin so rom_address is the frame base.
        anim_en = 1'b1;
        set_px(100, 50);
        vs_edges(8);
        cycle(256);
        vs_edges(24);
        cycle(0);
        anim_en = 1'b0;
        vs_edges(5);
        cycle(0);
        anim_en = 1'b1;
        vs_edges(7);
        cycle(0);
        vs_edges(1);
        cycle(256);
        vs_edges(8);
        cycle(512);

        // Reset mid-line with frame 2 and an opaque pixel in flight.
        rom_mem[545] = 2'd3;
        set_px(104, 58);
        cycle(545);
        cycle(545);
        cycle(545);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async_rgb", 32'({red, green, blue}), 32'h0);
        chk("reset_async_hit", 32'(hit), 32'h0);
        chk("reset_async_addr", 32'(rom_address), 32'd33);
        @(posedge vga_clk);
        @(posedge vga_clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle(33);
        cycle(33);
        cycle(33);
        chk("reset_recover_hit", 32'(hit), 32'h1);
        chk("reset_recover_rgb", 32'({red, green, blue}), 32'hF81);

        // Random pixels, positions, blanking, vs and animation enables.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) begin
                pos_x = 10'($urandom);
                pos_y = 10'($urandom);
            end
            DrawX = 10'(int'(pos_x) + int'($urandom_range(0, 80)) - 8);
            DrawY = 10'(int'(pos_y) + int'($urandom_range(0, 80)) - 8);
            blank = ($urandom_range(0, 7) != 0);
            sprite_en = ($urandom_range(0, 9) != 0);
            flip_x = 1'($urandom_range(0, 1));
            anim_en = ($urandom_range(0, 3) != 0);
            vs = ($urandom_range(0, 2) != 0);
            {bg_red, bg_green, bg_blue} = 12'($urandom);
            cycle(-1);
        end
        vs = 1'b1;
        blank = 1'b0;
        cycle(-1);
        cycle(-1);
        cycle(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised, animated sprite renderer for the VGA pixel path. For each pixel it tests DrawX/DrawY against a movable, integer-scaled sprite box and fetches a palette index from an external synchronous sprite ROM holding FRAMES animation frames. It treats index 0 as transparent and composites the palette colour over a background colour. It sits between the VGA controller and the next compositing layer, and its outputs are registered for direct drive of the DAC pins.

## Interface
- SPR_W, 16: sprite width in source pixels.
- SPR_H, 16: sprite height in source pixels.
- SCALE_SH, 2: on-screen scale is 2^SCALE_SH; legal range 0..3.
- FRAMES, 4: number of animation frames stored back-to-back in the ROM.
- FRAME_PERIOD, 8: number of vsync periods each animation frame is shown.
- IDX_W, 2: palette index width.
- ADDR_W, $clog2(FRAMES*SPR_W*SPR_H): ROM address width.

- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- blank  in  1  1 = active video.
- vs  in  1  vertical sync, active low.
- pos_x, pos_y  in  10 each  screen position of the sprite's top-left corner.
- sprite_en  in  1  0 = sprite never hits.
- anim_en  in  1  1 = animation advances.
- flip_x  in  1  horizontal mirror.
- bg_red, bg_green, bg_blue  in  4 each  background colour, aligned with DrawX/DrawY.
- rom_address  out  ADDR_W  sprite ROM address; combinational.
- rom_q  in  IDX_W  ROM data, valid one cycle after its address.
- pal_index  out  IDX_W  equals rom_q.
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- hit  out  1  registered; 1 = an opaque sprite pixel is being shown.

## Operation
- Local coordinates use 11-bit signed subtraction: dx = DrawX - pos_x and dy = DrawY - pos_y.
- in_box = sprite_en & dx >= 0 & dy >= 0 & (dx >> SCALE_SH) < SPR_W & (dy >> SCALE_SH) < SPR_H.
- lx = dx >> SCALE_SH. When flip_x is 1, lx is replaced by SPR_W-1-lx. ly = dy >> SCALE_SH.
- rom_address = frame*SPR_W*SPR_H + ly*SPR_W + lx when in_box, else 0.
- in_box, blank and the background colour are delayed one cycle to align with rom_q.
- Output select, using the aligned signals:
  - blank = 0: colour 0, hit = 0.
  - in_box and rom_q ≠ 0: pal_* colour, hit = 1.
  - otherwise: bg_* colour, hit = 0.
- Animation state machine:
  - tick counter 0..FRAME_PERIOD-1 and frame counter 0..FRAMES-1.
  - A falling edge of vs, detected against a registered copy of vs, with anim_en = 1 increments tick.
  - When tick wraps from FRAME_PERIOD-1 to 0, frame increments and wraps from FRAMES-1 to 0.
  - anim_en = 0 freezes both counters. Toggling anim_en does not reset them.
- frame changes only on a vs edge, so a frame never changes within the visible area.
- Sprites partly off-screen clip naturally. Coordinates where dx or dy is negative are out of the box.

## Timing
- A pixel whose inputs are valid in cycle n appears on red/green/blue/hit in cycle n+2.
  - The ROM is clocked at the end of cycle n.
  - The output register loads at the end of cycle n+1.
- vs-edge detection adds one cycle; frame updates one cycle after the vs falling edge is sampled.
- Reset (asynchronous, active-high):
  - Forces red, green, blue = 0, hit = 0, tick = 0, frame = 0, delayed vs = 1, and all pipeline registers = 0.
  - Reset asserted mid-line takes effect immediately.
  - After release, the first valid output appears two cycles later.
- Simultaneous vs falling edge and tick wrap at frame = FRAMES-1: frame becomes 0 and tick becomes 0 in the same cycle.

## Configuration
- SPRITE_FLIP_EN defined: flip_x is honoured as above.
- Not defined: flip_x is ignored and lx is never mirrored. The port remains present.

## Test plan
- Box and address: SPR_W = SPR_H = 16, SCALE_SH = 2, pos = (100, 50), frame 0.
  - DrawX = 104, DrawY = 58 -> rom_address = 33.
  - DrawX = 99 or 164 -> rom_address = 0, and two cycles later hit = 0 with bg colour.
- Transparency: in_box with rom_q = 0 -> bg colour, hit = 0. With rom_q = 2 and pal = (F, 8, 1) -> red/green/blue = F/8/1, hit = 1, exactly two cycles after the pixel.
- Blanking: blank = 0 during an opaque hit -> outputs 0 and hit = 0, after the same two-cycle latency.
- Animation: FRAMES = 4, FRAME_PERIOD = 8, anim_en = 1.
  - 8 vs falling edges -> frame 1, and the address base becomes 256.
  - After 32 edges -> frame wraps to 0.
  - anim_en = 0 for 5 edges -> frame and tick unchanged.
- Flip: SPRITE_FLIP_EN defined, flip_x = 1, dx = 0 -> lx = 15 and rom_address = 15 at row 0. With the macro undefined -> rom_address = 0.
- Reset: assert reset mid-frame with frame = 2 -> outputs 0 and frame 0 immediately. Release -> a valid pixel appears two cycles later.
